// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline buffers:
// control-flag bit positions and occupancy state encoding.
package pipe_pkg;

    localparam int CTRL_W = 14;

    localparam int CTRL_ISST    = 0;
    localparam int CTRL_ISLD    = 1;
    localparam int CTRL_ISBEQ   = 2;
    localparam int CTRL_ISBGT   = 3;
    localparam int CTRL_ISRET   = 4;
    localparam int CTRL_ISIMM   = 5;
    localparam int CTRL_ISWB    = 6;
    localparam int CTRL_ISUBR   = 7;
    localparam int CTRL_ISCALL  = 8;
    localparam int CTRL_ALU_LSB = 9;
    localparam int CTRL_ALU_MSB = 13;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_slot.sv
// One beat register of a pipeline buffer: load-enabled,
// asynchronously cleared to zero.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Valid/ready inter-stage pipeline register with flush and an
// optional skid slot; ctrl flags read as zero on bubbles.
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instruction,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_branchtarget,
    input  logic [DATA_W-1:0] in_op2,
    input  logic [DATA_W-1:0] in_aluresult,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instruction,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_branchtarget,
    output logic [DATA_W-1:0] out_op2,
    output logic [DATA_W-1:0] out_aluresult,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    localparam int BEAT_W = 5 * DATA_W + CTRL_W;

    occ_e              state;
    occ_e              state_nx;
    logic              push;
    logic              pop;
    logic              head_load;
    logic [BEAT_W-1:0] head_d;
    logic [BEAT_W-1:0] head_q;
    logic [BEAT_W-1:0] skid_q;
    logic [BEAT_W-1:0] in_beat;
    logic [CTRL_W-1:0] head_ctrl;

    assign in_beat = {in_instruction, in_pc, in_branchtarget,
                      in_op2, in_aluresult, in_ctrl};

    assign out_valid = (state != OCC_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign occupancy = state;

    always_comb begin
        state_nx  = state;
        head_load = 1'b0;
        head_d    = in_beat;
        if (flush) begin
            state_nx = OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (push) begin
                        head_load = 1'b1;
                        state_nx  = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head_load = 1'b1;
                    end else if (push) begin
                        state_nx = (SKID != 0) ? OCC_TWO : OCC_ONE;
                    end else if (pop) begin
                        state_nx = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        head_load = 1'b1;
                        head_d    = skid_q;
                        state_nx  = OCC_ONE;
                    end
                end
                default: state_nx = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OCC_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    pipe_slot #(.W(BEAT_W)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (head_load),
        .d     (head_d),
        .q     (head_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic ready_q;
            logic skid_load;

            // Registered ready: upstream never sees a path from out_ready.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= (state_nx != OCC_TWO);
                end
            end

            assign in_ready  = ready_q;
            assign skid_load = !flush && push && !pop
                               && (state == OCC_ONE);

            pipe_slot #(.W(BEAT_W)) u_skid (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (skid_load),
                .d     (in_beat),
                .q     (skid_q)
            );
        end else begin : g_noskid
            assign in_ready = !out_valid | out_ready;
            assign skid_q   = '0;
        end
    endgenerate

    assign {out_instruction, out_pc, out_branchtarget,
            out_op2, out_aluresult, head_ctrl} = head_q;

    assign out_ctrl = out_valid ? head_ctrl : '0;

endmodule
